// File: rtl/rx_segment_router.sv
// Header parser and segment dispatcher: validates MAC/IP/port fields, replays each
// frame through a fixed delay line to one segment channel, and muxes channel outputs back.
module rx_segment_router #(
  parameter int          SEG_NUM  = 50,
  parameter int          SEG_OFS  = 50,
  parameter int          MAC_OFS  = 8,
  parameter int          IP_OFS   = 34,
  parameter int          PORT_OFS = 44,
  parameter logic [47:0] DST_MAC  = 48'hdeadbeef0123,
  parameter logic [31:0] SRC_IP   = 32'hc0a80140,
  parameter logic [15:0] DST_PORT = 16'h0102,
  parameter int          CNT_W    = 16
) (
  input  logic                   clk125MHz,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_enable,
  output logic [7:0]             seg_data,
  output logic [SEG_NUM-1:0]     seg_en,
  input  logic [SEG_NUM-1:0]     ch_en,
  input  logic [8*SEG_NUM-1:0]   ch_data,
  input  logic [SEG_NUM-1:0]     ch_loss,
  output logic                   en_out,
  output logic [7:0]             data_out,
  output logic                   loss_detected,
  output logic [15:0]            last_seg,
  output logic [CNT_W-1:0]       cnt_ok,
  output logic [CNT_W-1:0]       cnt_drop,
  output logic [CNT_W-1:0]       cnt_range
);
  localparam int          DLY   = SEG_OFS + 3;
  localparam int          SEL_W = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
  localparam logic [31:0] K_MAX = '1;

  logic [31:0]              k_q, k_d;
  logic                     valid_q, valid_d, vcur, hdr_ok, hdr_chk;
  logic [7:0]               hdr_exp, msb_q, msb_d;
  logic [47:0]              mac_sh;
  logic [31:0]              ip_sh;
  logic [15:0]              port_sh;
  logic [15:0]              seg;
  logic                     decide, in_range, routed, runt, dly_start;
  logic                     pend_vld_q, pend_vld_d, route_vld_q, route_vld_d;
  logic [15:0]              pend_seg_q, pend_seg_d, route_q, route_d;
  logic [DLY-1:0]           vld_pipe_q, vld_pipe_d;
  logic [DLY-1:0][7:0]      dat_pipe_q, dat_pipe_d;
  logic [CNT_W-1:0]         cnt_ok_q, cnt_ok_d, cnt_drop_q, cnt_drop_d, cnt_range_q, cnt_range_d;
  logic [15:0]              last_seg_q, last_seg_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic                     found;
  logic                     en_out_q, en_out_d, loss_q, loss_d;
  logic [7:0]               dout_q, dout_d;

  // Expected header byte for the current index, MSB first within each field.
  always_comb begin
    hdr_chk = 1'b0;
    hdr_exp = 8'h00;
    mac_sh  = '0;
    ip_sh   = '0;
    port_sh = '0;
    if (k_q >= 32'(MAC_OFS) && k_q < 32'(MAC_OFS + 6)) begin
      hdr_chk = 1'b1;
      mac_sh  = DST_MAC << (8 * (k_q - 32'(MAC_OFS)));
      hdr_exp = mac_sh[47:40];
    end else if (k_q >= 32'(IP_OFS) && k_q < 32'(IP_OFS + 4)) begin
      hdr_chk = 1'b1;
      ip_sh   = SRC_IP << (8 * (k_q - 32'(IP_OFS)));
      hdr_exp = ip_sh[31:24];
    end else if (k_q >= 32'(PORT_OFS) && k_q < 32'(PORT_OFS + 2)) begin
      hdr_chk = 1'b1;
      port_sh = DST_PORT << (8 * (k_q - 32'(PORT_OFS)));
      hdr_exp = port_sh[15:8];
    end
    hdr_ok = !(hdr_chk && (rx_data != hdr_exp));
  end

  always_comb begin
    // k_q is the index of the byte arriving now; it saturates so it never wraps back to a start.
    k_d      = rx_enable ? ((k_q == K_MAX) ? k_q : k_q + 32'd1) : '0;
    vcur     = ((k_q == '0) ? 1'b1 : valid_q) & hdr_ok;
    valid_d  = rx_enable ? vcur : valid_q;
    msb_d    = (rx_enable && k_q == 32'(SEG_OFS)) ? rx_data : msb_q;
    seg      = {msb_q, rx_data};
    decide   = rx_enable && (k_q == 32'(SEG_OFS + 1));
    in_range = 32'(seg) < 32'(SEG_NUM);
    routed   = decide && vcur && in_range;
    runt     = !rx_enable && (k_q != '0) && (k_q < 32'(SEG_OFS + 2));

    cnt_ok_d    = cnt_ok_q;
    cnt_drop_d  = cnt_drop_q;
    cnt_range_d = cnt_range_q;
    last_seg_d  = last_seg_q;
    if (routed) begin
      cnt_ok_d   = cnt_ok_q + CNT_W'(1);
      last_seg_d = seg;
    end
    if (decide && vcur && !in_range) cnt_range_d = cnt_range_q + CNT_W'(1);
    if ((decide && !vcur) || runt)   cnt_drop_d  = cnt_drop_q + CNT_W'(1);

    vld_pipe_d = {vld_pipe_q[DLY-2:0], rx_enable};
    dat_pipe_d = {dat_pipe_q[DLY-2:0], rx_data};

    // Load the route one cycle early so it is ready on the first delayed byte.
    dly_start   = vld_pipe_q[DLY-2] && !vld_pipe_q[DLY-1];
    pend_vld_d  = pend_vld_q;
    pend_seg_d  = pend_seg_q;
    route_vld_d = route_vld_q;
    route_d     = route_q;
    if (dly_start) begin
      route_vld_d = pend_vld_q;
      route_d     = pend_seg_q;
      pend_vld_d  = 1'b0;
    end
    if (decide) begin
      pend_vld_d = routed;
      pend_seg_d = seg;
    end
  end

  always_comb begin
    sel_d = sel_q;
    found = 1'b0;
    for (int i = 0; i < SEG_NUM; i++) begin
      if (ch_en[i] && !found) begin
        sel_d = SEL_W'(i);
        found = 1'b1;
      end
    end
    en_out_d = ch_en[sel_d];
    loss_d   = ch_loss[sel_d];
    dout_d   = ch_data[32'(sel_d) * 8 +: 8];
  end

  always_ff @(posedge clk125MHz or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= '0;
      valid_q     <= 1'b0;
      msb_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_seg_q  <= '0;
      route_vld_q <= 1'b0;
      route_q     <= '0;
      vld_pipe_q  <= '0;
      dat_pipe_q  <= '0;
      cnt_ok_q    <= '0;
      cnt_drop_q  <= '0;
      cnt_range_q <= '0;
      last_seg_q  <= '0;
      sel_q       <= '0;
      en_out_q    <= 1'b0;
      loss_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      k_q         <= k_d;
      valid_q     <= valid_d;
      msb_q       <= msb_d;
      pend_vld_q  <= pend_vld_d;
      pend_seg_q  <= pend_seg_d;
      route_vld_q <= route_vld_d;
      route_q     <= route_d;
      vld_pipe_q  <= vld_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_drop_q  <= cnt_drop_d;
      cnt_range_q <= cnt_range_d;
      last_seg_q  <= last_seg_d;
      sel_q       <= sel_d;
      en_out_q    <= en_out_d;
      loss_q      <= loss_d;
      dout_q      <= dout_d;
    end
  end

  always_comb begin
    seg_en = '0;
    if (vld_pipe_q[DLY-1] && route_vld_q) seg_en = SEG_NUM'(1) << route_q;
  end

  assign seg_data      = dat_pipe_q[DLY-1];
  assign en_out        = en_out_q;
  assign data_out      = dout_q;
  assign loss_detected = loss_q;
  assign last_seg      = last_seg_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_drop      = cnt_drop_q;
  assign cnt_range     = cnt_range_q;
endmodule

// File: tb/tb_rx_segment_router.sv
// Randomized bench for rx_segment_router: frames are judged from their bytes and
// expected outputs are kept per cycle in a timeline scoreboard.
module tb_rx_segment_router;
  localparam int          SEG_NUM  = 50;
  localparam int          SEG_OFS  = 50;
  localparam int          MAC_OFS  = 8;
  localparam int          IP_OFS   = 34;
  localparam int          PORT_OFS = 44;
  localparam logic [47:0] DST_MAC  = 48'hdeadbeef0123;
  localparam logic [31:0] SRC_IP   = 32'hc0a80140;
  localparam logic [15:0] DST_PORT = 16'h0102;
  localparam int          CNT_W    = 16;
  localparam int          DLY      = SEG_OFS + 3;
  localparam int          NCYC     = 16384;

  logic                 clk125MHz = 1'b0;
  logic                 reset_n   = 1'b0;
  logic [7:0]           rx_data   = '0;
  logic                 rx_enable = 1'b0;
  logic [7:0]           seg_data;
  logic [SEG_NUM-1:0]   seg_en;
  logic [SEG_NUM-1:0]   ch_en     = '0;
  logic [8*SEG_NUM-1:0] ch_data   = '0;
  logic [SEG_NUM-1:0]   ch_loss   = '0;
  logic                 en_out, loss_detected;
  logic [7:0]           data_out;
  logic [15:0]          last_seg;
  logic [CNT_W-1:0]     cnt_ok, cnt_drop, cnt_range;

  rx_segment_router #(
    .SEG_NUM(SEG_NUM), .SEG_OFS(SEG_OFS), .MAC_OFS(MAC_OFS), .IP_OFS(IP_OFS),
    .PORT_OFS(PORT_OFS), .DST_MAC(DST_MAC), .SRC_IP(SRC_IP), .DST_PORT(DST_PORT), .CNT_W(CNT_W)
  ) dut (
    .clk125MHz(clk125MHz), .reset_n(reset_n), .rx_data(rx_data), .rx_enable(rx_enable),
    .seg_data(seg_data), .seg_en(seg_en), .ch_en(ch_en), .ch_data(ch_data), .ch_loss(ch_loss),
    .en_out(en_out), .data_out(data_out), .loss_detected(loss_detected), .last_seg(last_seg),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop), .cnt_range(cnt_range)
  );

  always #4 clk125MHz = ~clk125MHz;

  int cyc = 0;
  always @(posedge clk125MHz) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Timeline: what went in each cycle, and when each counter event must become visible.
  logic       in_en   [NCYC];
  logic [7:0] in_dat  [NCYC];
  int         in_ch   [NCYC];
  int         inc_ok  [NCYC];
  int         inc_drop[NCYC];
  int         inc_rng [NCYC];
  int         set_last[NCYC];
  int         exp_ok = 0, exp_drop = 0, exp_rng = 0, exp_last = 0;
  bit         sb_on = 0;
  logic [SEG_NUM-1:0] e_en;
  logic [7:0]         e_dat;

  always @(negedge clk125MHz) begin : scoreboard
    if (sb_on && cyc < NCYC) begin
      exp_ok   += inc_ok[cyc];
      exp_drop += inc_drop[cyc];
      exp_rng  += inc_rng[cyc];
      if (set_last[cyc] != 0) exp_last = set_last[cyc] - 1;
      e_en  = '0;
      e_dat = '0;
      if (cyc >= DLY) begin
        e_dat = in_dat[cyc-DLY];
        if (in_en[cyc-DLY] && in_ch[cyc-DLY] != 0) e_en[in_ch[cyc-DLY]-1] = 1'b1;
      end
      chk("seg_data", 64'(seg_data), 64'(e_dat));
      chk("seg_en", 64'(seg_en), 64'(e_en));
      chk("cnt_ok", 64'(cnt_ok), 64'(exp_ok % (1 << CNT_W)));
      chk("cnt_drop", 64'(cnt_drop), 64'(exp_drop % (1 << CNT_W)));
      chk("cnt_range", 64'(cnt_range), 64'(exp_rng % (1 << CNT_W)));
      chk("last_seg", 64'(last_seg), 64'(exp_last));
    end
  end

  task automatic drive(input logic en, input logic [7:0] d, input int ch);
    @(posedge clk125MHz); #1;
    rx_enable = en;
    rx_data   = d;
    if (cyc < NCYC) begin
      in_en[cyc] = en; in_dat[cyc] = d; in_ch[cyc] = ch;
    end
  endtask

  logic [7:0] frame_buf [0:127];

  task automatic make_frame(input bit corrupt, input int seg, input int len);
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    int pos;
    mac = DST_MAC; ip = SRC_IP; port = DST_PORT;
    for (int i = 0; i < 128; i++) frame_buf[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) frame_buf[MAC_OFS+i]  = mac[47-8*i -: 8];
    for (int i = 0; i < 4; i++) frame_buf[IP_OFS+i]   = ip[31-8*i -: 8];
    for (int i = 0; i < 2; i++) frame_buf[PORT_OFS+i] = port[15-8*i -: 8];
    frame_buf[SEG_OFS]   = 8'(seg >> 8);
    frame_buf[SEG_OFS+1] = 8'(seg);
    if (corrupt) begin
      pos = $urandom_range(0, 11);
      pos = (pos < 6) ? MAC_OFS + pos : (pos < 10) ? IP_OFS + pos - 6 : PORT_OFS + pos - 10;
      frame_buf[pos] = frame_buf[pos] ^ 8'($urandom_range(1, 255));
    end
    if (len < 128) frame_buf[len] = frame_buf[len];
  endtask

  // Judge the frame from its bytes, book its outcome on the timeline, then send it.
  task automatic send_frame(input int len, input int gap);
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    bit ok;
    int seg, ch, t0;
    mac = DST_MAC; ip = SRC_IP; port = DST_PORT;
    ok = 1;
    for (int i = 0; i < 6; i++) if (frame_buf[MAC_OFS+i]  != mac[47-8*i -: 8])  ok = 0;
    for (int i = 0; i < 4; i++) if (frame_buf[IP_OFS+i]   != ip[31-8*i -: 8])   ok = 0;
    for (int i = 0; i < 2; i++) if (frame_buf[PORT_OFS+i] != port[15-8*i -: 8]) ok = 0;
    seg = frame_buf[SEG_OFS] * 256 + frame_buf[SEG_OFS+1];
    ch  = (len >= SEG_OFS + 2 && ok && seg < SEG_NUM) ? seg + 1 : 0;
    t0  = 0;
    for (int i = 0; i < len; i++) begin
      drive(1'b1, frame_buf[i], ch);
      if (i == 0) begin
        t0 = cyc;
        if (t0 + len + 2 < NCYC) begin
          if (len < SEG_OFS + 2)   inc_drop[t0+len+1]   += 1;
          else if (!ok)            inc_drop[t0+SEG_OFS+2] += 1;
          else if (seg >= SEG_NUM) inc_rng[t0+SEG_OFS+2]  += 1;
          else begin
            inc_ok[t0+SEG_OFS+2]  += 1;
            set_last[t0+SEG_OFS+2] = seg + 1;
          end
        end
      end
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'($urandom), 0);
  endtask

  int msel;
  logic       s_en, s_loss;
  logic [7:0] s_dat;
  int hits = 0, stray = 0;
  bit cnt_on = 0;
  logic [SEG_NUM-1:0] hit_mask = '0;

  always @(negedge clk125MHz) begin : route_counter
    if (cnt_on) begin
      if (seg_en == hit_mask) hits++;
      else if (seg_en != '0) stray++;
    end
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      in_en[i] = 0; in_dat[i] = 0; in_ch[i] = 0;
      inc_ok[i] = 0; inc_drop[i] = 0; inc_rng[i] = 0; set_last[i] = 0;
    end
    repeat (3) @(posedge clk125MHz);
    @(negedge clk125MHz);
    chk("rst_seg_en", 64'(seg_en), 64'd0);
    chk("rst_cnt_ok", 64'(cnt_ok), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    @(posedge clk125MHz); #1;
    reset_n = 1'b1;
    sb_on   = 1;
    repeat (2) drive(1'b0, 8'h00, 0);

    // Directed frames.
    make_frame(0, 3, 100);  send_frame(100, 1);
    make_frame(0, 3, 100);  frame_buf[IP_OFS+3] = 8'h41; send_frame(100, 1);
    make_frame(0, 50, 100); send_frame(100, 1);
    make_frame(0, 7, 20);   send_frame(20, 1);
    make_frame(0, 7, 90);   send_frame(90, 1);
    make_frame(0, 1, 60);   send_frame(60, 1);
    make_frame(0, 2, 60);   send_frame(60, 1);
    repeat (DLY + 5) drive(1'b0, 8'h00, 0);
    chk("dir_cnt_ok", 64'(cnt_ok), 64'd4);
    chk("dir_cnt_drop", 64'(cnt_drop), 64'd2);
    chk("dir_cnt_range", 64'(cnt_range), 64'd1);
    chk("dir_last_seg", 64'(last_seg), 64'd2);

    // Random frames: good, out-of-range, bad header, runt.
    for (int n = 0; n < 40; n++) begin
      int r, len, seg;
      r   = $urandom_range(0, 9);
      len = (r == 9) ? $urandom_range(1, SEG_OFS + 1) : $urandom_range(SEG_OFS + 2, 120);
      seg = (r == 5 || r == 6) ? $urandom_range(SEG_NUM, 65535) : $urandom_range(0, SEG_NUM - 1);
      make_frame(r == 7 || r == 8, seg, len);
      send_frame(len, $urandom_range(1, 3));
    end
    repeat (DLY + 5) drive(1'b0, 8'h00, 0);

    // Output selector: lowest active index wins, otherwise hold the last choice.
    msel = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk125MHz); #1;
      for (int i = 0; i < SEG_NUM; i++) ch_data[8*i +: 8] = 8'($urandom);
      ch_loss = '0;
      for (int i = 0; i < SEG_NUM; i++) ch_loss[i] = 1'($urandom);
      ch_en = '0;
      if (n == 0) begin
        ch_en[5] = 1'b1; ch_en[9] = 1'b1; ch_data[5*8 +: 8] = 8'hAA;
      end else if (n > 2 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 3; k++) ch_en[$urandom_range(0, SEG_NUM - 1)] = 1'b1;
      end
      for (int i = SEG_NUM - 1; i >= 0; i--) if (ch_en[i]) msel = i;
      s_en   = ch_en[msel];
      s_loss = ch_loss[msel];
      s_dat  = ch_data[8*msel +: 8];
      @(posedge clk125MHz);
      @(negedge clk125MHz);
      chk("sel_data_out", 64'(data_out), 64'(s_dat));
      chk("sel_en_out", 64'(en_out), 64'(s_en));
      chk("sel_loss", 64'(loss_detected), 64'(s_loss));
    end

    // Mid-frame reset, then a frame already in progress when reset releases.
    sb_on = 0;
    @(posedge clk125MHz); #1;
    ch_en = '0; ch_en[7] = 1'b1; ch_loss = '1; ch_data[7*8 +: 8] = 8'h5C;
    make_frame(0, 11, 80);
    for (int i = 0; i < 30; i++) drive(1'b1, frame_buf[i], 0);
    chk("pre_rst_data_out", 64'(data_out), 64'h5C);
    @(posedge clk125MHz); #1;
    reset_n = 1'b0; rx_data = 8'h77;
    #1;
    chk("arst_seg_en", 64'(seg_en), 64'd0);
    chk("arst_seg_data", 64'(seg_data), 64'd0);
    chk("arst_cnt_ok", 64'(cnt_ok), 64'd0);
    chk("arst_cnt_drop", 64'(cnt_drop), 64'd0);
    chk("arst_cnt_range", 64'(cnt_range), 64'd0);
    chk("arst_last_seg", 64'(last_seg), 64'd0);
    chk("arst_data_out", 64'(data_out), 64'd0);
    chk("arst_en_out", 64'(en_out), 64'd0);
    chk("arst_loss", 64'(loss_detected), 64'd0);
    repeat (2) @(posedge clk125MHz);
    make_frame(0, 13, 70);
    hit_mask = '0; hit_mask[13] = 1'b1;
    @(posedge clk125MHz); #1;
    reset_n = 1'b1; rx_enable = 1'b1; rx_data = frame_buf[0];
    cnt_on = 1;
    for (int i = 1; i < 70; i++) drive(1'b1, frame_buf[i], 0);
    repeat (DLY + 10) drive(1'b0, 8'h00, 0);
    cnt_on = 0;
    chk("rel_cnt_ok", 64'(cnt_ok), 64'd1);
    chk("rel_cnt_drop", 64'(cnt_drop), 64'd0);
    chk("rel_last_seg", 64'(last_seg), 64'd13);
    chk("rel_seg_en_len", 64'(hits), 64'd70);
    chk("rel_seg_en_stray", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
